me_frame_buffer: RTL

- Frame-memory stage directly upstream of the motion-estimation core.
- Accepts a byte stream holding one 16x16 reference block followed by one 32x32 search window, stores both, then asserts `start`.
- While the core runs, it serves R, S1 and S2 from the core's AddressR/AddressS1/AddressS2 with fixed one-cycle latency.
- Tracks `completed` to re-arm for the next frame and counts finished frames.

---
 rtl/me_frame_buffer.sv | 117 +++++++++++
 1 files changed

// File: rtl/me_frame_buffer.sv
// Frame memory in front of the motion-estimation core: loads one 16x16
// reference block and one 32x32 search window from a byte stream, then
// raises start and serves R/S1/S2 with one-cycle registered reads.
module me_frame_buffer #(
    parameter int RMEM_MAX = 256,
    parameter int SMEM_MAX = 1024,
    parameter int DATA_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [DATA_W-1:0]           load_data,
    output logic                        start,
    input  logic                        completed,
    input  logic [$clog2(RMEM_MAX)-1:0] AddressR,
    input  logic [$clog2(SMEM_MAX)-1:0] AddressS1,
    input  logic [$clog2(SMEM_MAX)-1:0] AddressS2,
    output logic [DATA_W-1:0]           R,
    output logic [DATA_W-1:0]           S1,
    output logic [DATA_W-1:0]           S2,
    output logic                        busy,
    output logic                        frame_done,
    output logic [15:0]                 frame_count
);

    localparam int RA_W  = $clog2(RMEM_MAX);
    localparam int CNT_W = $clog2(SMEM_MAX);

    typedef enum logic [1:0] {LOAD_R, LOAD_S, RUN, DONE} state_t;

    state_t             state, nextState;
    logic [CNT_W-1:0]   cnt;
    logic               xfer;
    logic               lastBeat;

    logic [DATA_W-1:0]  rmem [RMEM_MAX];
    logic [DATA_W-1:0]  smem [SMEM_MAX];

    // Beat accounting: a beat moves only when both sides agree, and the
    // final beat of each region closes that region.
    always_comb begin
        xfer     = load_valid & load_ready;
        lastBeat = ((state == LOAD_R) && (cnt == CNT_W'(RMEM_MAX - 1))) ||
                   ((state == LOAD_S) && (cnt == CNT_W'(SMEM_MAX - 1)));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD_R;
        else       state <= nextState;
    end

    // Next state and state-decoded outputs; completed only matters in RUN.
    always_comb begin
        nextState  = state;
        load_ready = 1'b0;
        start      = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            LOAD_R: begin
                load_ready = 1'b1;
                if (xfer && lastBeat) nextState = LOAD_S;
            end
            LOAD_S: begin
                load_ready = 1'b1;
                if (xfer && lastBeat) nextState = RUN;
            end
            RUN: begin
                start = 1'b1;
                busy  = 1'b1;
                if (completed) nextState = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                nextState  = LOAD_R;
            end
            default: nextState = LOAD_R;
        endcase
    end

    // Load address counter; holds through gaps, clears at each region end.
    always_ff @(posedge clk) begin
        if (reset)     cnt <= '0;
        else if (xfer) cnt <= lastBeat ? '0 : cnt + 1'b1;
    end

    // Finished-frame counter, free-running wrap.
    always_ff @(posedge clk) begin
        if (reset)                frame_count <= '0;
        else if (state == DONE)   frame_count <= frame_count + 16'd1;
    end

    // Memory writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!reset && xfer) begin
            if (state == LOAD_R) rmem[cnt[RA_W-1:0]] <= load_data;
            else                 smem[cnt]           <= load_data;
        end
    end

    // Registered reads every cycle; nonblocking gives read-before-write.
    always_ff @(posedge clk) begin
        if (reset) begin
            R  <= '0;
            S1 <= '0;
            S2 <= '0;
        end else begin
            R  <= rmem[AddressR];
            S1 <= smem[AddressS1];
            S2 <= smem[AddressS2];
        end
    end

endmodule
